// File: rtl/seq_gen.sv
// Serial pattern transmitter: parallel words in, MSB-first bit stream out, optional idle gap per word.
// Latency: 2 cycles from acceptance (while idle) to first bit; back-to-back words stream with no bubble.
// Backpressure: load_ready is low while the one-word holding buffer is full; offered data is held by the source.
`timescale 1ns/1ps
module seq_gen #(
    parameter int WIDTH = 32,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
    localparam logic [7:0]      GAP_LD   = 8'(GAP);
    localparam bit              HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;
    logic [7:0]       gapcnt;

    // Loads only land when hold is empty and transfers only fire when it is full,
    // so the two never touch hold_full on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            gapcnt     <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;

            if (load_valid && !hold_full) begin
                hold      <= load_data;
                hold_full <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (hold_full) begin
                        shreg     <= hold;
                        hold_full <= 1'b0;
                        bitcnt    <= '0;
                        state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    dout       <= shreg[WIDTH-1];
                    dout_valid <= 1'b1;
                    word_done  <= (bitcnt == LAST_BIT);
                    shreg      <= shreg << 1;
                    bitcnt     <= bitcnt + CW'(1);
                    if (bitcnt == LAST_BIT) begin
                        if (HAS_GAP) begin
                            gapcnt <= GAP_LD;
                            state  <= S_GAP;
                        end else if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            bitcnt    <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_GAP: begin
                    gapcnt <= gapcnt - 8'd1;
                    if (gapcnt == 8'd1) begin
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            bitcnt    <= '0;
                            state     <= S_SHIFT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign load_ready = !hold_full;
    assign busy       = (state != S_IDLE) || hold_full;

endmodule
